// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding / hazard controller.
// Holds the operand-mux select encoding, the pipeline tracking slot record,
// the controller state encoding and the slot hazard-match helper.
package fwd_hazard_ctrl_pkg;

    // Operand-mux select encoding, fixed by the existing 3-input mux wiring:
    // input_b = register file, input_a = EX/MEM result, input_c = MEM/WB result.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    // Register indices are stored zero-extended to this width so the slot
    // record can live in the package; REG_ADDR_W must not exceed it.
    localparam int SLOT_RD_W = 8;
    typedef logic [SLOT_RD_W-1:0] slot_rd_t;

    typedef struct packed {
        logic     valid;
        slot_rd_t rd;
        logic     reg_write;
        logic     mem_read;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    localparam slot_t SLOT_BUBBLE = '{
        valid:     1'b0,
        rd:        {SLOT_RD_W{1'b0}},
        reg_write: 1'b0,
        mem_read:  1'b0
    };

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } ctrl_state_e;

    // A slot supplies a source operand when it holds a live register write
    // to that register; x0 is hard-wired zero and never matches.
    function automatic logic slot_hit(input slot_t s, input slot_rd_t rs);
        return s.valid & s.reg_write & (s.rd == rs) & (rs != {SLOT_RD_W{1'b0}});
    endfunction

endpackage

// File: rtl/fwd_slot_pipe.sv
// Three-deep tracking shift register (EX -> MEM -> WB) mirroring the
// instructions in flight after decode.
// Ports:
//   clk        clock, all updates on rising edge
//   arst_n     synchronous active-low reset, empties every slot
//   load_en_i  1: EX slot takes id_slot_i; 0: EX slot takes a bubble
//   id_slot_i  decode-stage record (packed slot_t)
//   ex_o, mem_o, wb_o  current slot contents (packed slot_t)
module fwd_slot_pipe
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load_en_i,
    input  logic [SLOT_W-1:0] id_slot_i,
    output logic [SLOT_W-1:0] ex_o,
    output logic [SLOT_W-1:0] mem_o,
    output logic [SLOT_W-1:0] wb_o
);

    slot_t ex_q;
    slot_t mem_q;
    slot_t wb_q;
    slot_t ex_d;

    // Select what enters the EX slot: the decoded instruction or a bubble.
    always_comb begin
        ex_d = SLOT_BUBBLE;
        if (load_en_i) begin
            ex_d = slot_t'(id_slot_i);
        end else begin
            ex_d = SLOT_BUBBLE;
        end
    end

    // Advance the tracking pipeline every cycle.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ex_q  <= SLOT_BUBBLE;
            mem_q <= SLOT_BUBBLE;
            wb_q  <= SLOT_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a 5-stage pipeline.
// Ports:
//   clk, arst_n                         clock, synchronous active-low reset
//   id_valid, id_rs1, id_rs2, id_rd,
//   id_reg_write, id_mem_read           decode-stage instruction info
//   flush                               taken branch/jump: kill decode and execute
//   fwd_sel_a, fwd_sel_b                registered operand-mux selects for execute
//   stall                               hold PC and IF/ID (combinational)
//   ex_bubble                           ID/EX loads a NOP (combinational)
//   stall_cnt                           saturating count of load-use stall cycles
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic                  ex_bubble,
    output logic [CNT_W-1:0]      stall_cnt
);

    slot_rd_t    rs1_s;
    slot_rd_t    rs2_s;
    slot_t       id_slot_s;
    slot_t       slot_ex_s;
    slot_t       slot_mem_s;
    slot_t       slot_wb_unused_s;
    logic        load_use_s;
    logic        stall_s;
    logic        bubble_s;
    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic [1:0]  fwd_sel_a_q;
    logic [1:0]  fwd_sel_a_d;
    logic [1:0]  fwd_sel_b_q;
    logic [1:0]  fwd_sel_b_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign rs1_s = slot_rd_t'(id_rs1);
    assign rs2_s = slot_rd_t'(id_rs2);

    // Pack the decode-stage instruction into a tracking record.
    always_comb begin
        id_slot_s           = SLOT_BUBBLE;
        id_slot_s.valid     = id_valid;
        id_slot_s.rd        = slot_rd_t'(id_rd);
        id_slot_s.reg_write = id_reg_write;
        id_slot_s.mem_read  = id_mem_read;
    end

    // The WB slot only exists to age instructions out; distance-3 operands
    // come from the register file via write-before-read.
    fwd_slot_pipe u_slot_pipe (
        .clk       (clk),
        .arst_n    (arst_n),
        .load_en_i (~stall_s & ~flush),
        .id_slot_i (id_slot_s),
        .ex_o      (slot_ex_s),
        .mem_o     (slot_mem_s),
        .wb_o      (slot_wb_unused_s)
    );

    // A load in EX cannot forward yet; its consumer in decode must wait one cycle.
    assign load_use_s = id_valid & slot_ex_s.valid & slot_ex_s.mem_read
                      & (slot_hit(slot_ex_s, rs1_s) | slot_hit(slot_ex_s, rs2_s));

    // Newest producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] sel_for(input slot_t ex_s, input slot_t mem_s,
                                           input slot_rd_t rs);
        if (slot_hit(ex_s, rs)) begin
            return FWD_EXMEM;
        end else if (slot_hit(mem_s, rs)) begin
            return FWD_MEMWB;
        end else begin
            return FWD_REGFILE;
        end
    endfunction

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one stall cycle per load-use hazard, flush always returns to RUN.
    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_RUN;
                end else if (load_use_s) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Stall/bubble outputs; forced low while reset is asserted.
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        if (!arst_n) begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
        end else if (flush) begin
            stall_s  = 1'b0;
            bubble_s = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    stall_s  = load_use_s;
                    bubble_s = load_use_s;
                end
                ST_STALL: begin
                    stall_s  = 1'b0;
                    bubble_s = 1'b0;
                end
                default: begin
                    stall_s  = 1'b0;
                    bubble_s = 1'b0;
                end
            endcase
        end
    end

    // Next operand selects and saturating stall counter.
    always_comb begin
        fwd_sel_a_d = FWD_REGFILE;
        fwd_sel_b_d = FWD_REGFILE;
        stall_cnt_d = stall_cnt_q;
        if (flush | ~id_valid) begin
            fwd_sel_a_d = FWD_REGFILE;
            fwd_sel_b_d = FWD_REGFILE;
        end else begin
            fwd_sel_a_d = sel_for(slot_ex_s, slot_mem_s, rs1_s);
            fwd_sel_b_d = sel_for(slot_ex_s, slot_mem_s, rs2_s);
        end
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Registered selects and counter.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            fwd_sel_a_q <= FWD_REGFILE;
            fwd_sel_b_q <= FWD_REGFILE;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            fwd_sel_a_q <= fwd_sel_a_d;
            fwd_sel_b_q <= fwd_sel_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel_a = fwd_sel_a_q;
    assign fwd_sel_b = fwd_sel_b_q;
    assign stall     = stall_s;
    assign ex_bubble = bubble_s;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 arst_n  in  1  reset; synchronous, active-low.
REQ-005 id_valid  in  1  decode-stage instruction is valid.
REQ-006 id_rs1, id_rs2  in  REG_ADDR_W each  source registers of the decode-stage instruction.
REQ-007 id_rd  in  REG_ADDR_W  destination register of the decode-stage instruction.
REQ-008 id_reg_write  in  1  decode-stage instruction writes the register file.
REQ-009 id_mem_read  in  1  decode-stage instruction is a load.
REQ-010 flush  in  1  taken branch/jump; kill the decode and execute slots.
REQ-011 fwd_sel_a, fwd_sel_b  out  2 each  operand-mux selects for the execute stage: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 never driven.
REQ-012 stall  out  1  hold the PC and IF/ID registers this cycle.
REQ-013 ex_bubble  out  1  ID/EX register loads a NOP this cycle.
REQ-014 stall_cnt  out  CNT_W  number of load-use stall cycles since reset.

Function
REQ-015 Internal tracking slots EX, MEM and WB, each holding {valid, rd, reg_write, mem_read}, SHALL shift EX->MEM->WB every cycle.
REQ-016 The EX slot SHALL load decode-stage info when stall=0 and flush=0, and a bubble (valid=0) otherwise.
REQ-017 Hazard term hit(slot,rs) = slot.valid & slot.reg_write & (slot.rd == rs) & (rs != 0).
REQ-018 fwd_sel_x SHALL be registered and computed from the decode-stage rs and the pre-shift slot contents: next = 01 if hit(EX,rs); else 10 if hit(MEM,rs); else 00.
REQ-019 The EX/MEM match SHALL take priority over the MEM/WB match when both hit.
REQ-020 Selects SHALL therefore apply to the instruction in execute in the cycle after it leaves decode (latency 1).
REQ-021 Distance-3 dependencies SHALL NOT be forwarded; the register file resolves them with write-before-read.
REQ-022 Load-use hazard = id_valid & EX.valid & EX.mem_read & (hit(EX,id_rs1) | hit(EX,id_rs2)).
REQ-023 stall and ex_bubble SHALL be combinational and asserted in the same cycle as the load-use hazard, unless flush=1.
REQ-024 A load-use stall SHALL last exactly one cycle; the following cycle the load is in MEM, and the dependent instruction SHALL receive select 10.
REQ-025 Controller states: RUN (no stall) and STALL (one bubble inserted).
REQ-026 Transition RUN->STALL on a load-use hazard.
REQ-027 Transition STALL->RUN unconditionally on the next cycle.
REQ-028 When flush=1: stall=0, ex_bubble=1, next fwd_sel = 00, and the state SHALL go to RUN; flush overrides the hazard.
REQ-029 When id_valid=0: no hazard is detected, and next fwd_sel = 00.
REQ-030 stall_cnt SHALL increment on each cycle with stall=1 and saturate at all-ones (no wrap).

Reset
REQ-031 On a clk edge with arst_n=0: all slots invalid, state RUN, fwd_sel_a/b=00, stall_cnt=0.
REQ-032 stall and ex_bubble SHALL read 0 during reset.
REQ-033 A reset asserted during a stall SHALL abandon the stall, with no residual bubble after release.

Structure
REQ-034 The shared package SHALL hold the FWD_REGFILE/FWD_EXMEM/FWD_MEMWB select constants (00/01/10), the slot record typedef, and the RUN/STALL state encoding.
REQ-035 The select encoding SHALL match the existing 3-input operand mux wiring: input_b = register file, input_a = EX/MEM, input_c = MEM/WB.
REQ-036 There SHALL be one sub-module, fwd_slot_pipe: the three-deep tracking shift register with bubble insert.
REQ-037 The hazard and select logic SHALL be in the top module.

Verification
REQ-038 add x5 then sub uses rs1=x5 -> fwd_sel_a=01 in sub's execute cycle; stall stays 0.
REQ-039 add x5, nop, use x5 in rs2 -> fwd_sel_b=10.
REQ-040 Write x5, write x5 again, then use x5 -> fwd_sel=01 (newest producer wins).
REQ-041 lw x7 followed by use of x7 -> stall=1 and ex_bubble=1 for exactly 1 cycle; then fwd_sel=10; stall_cnt increments 0->1.
REQ-042 Producer writes x0, consumer reads x0 -> fwd_sel=00; a lw x0 hazard produces no stall.
REQ-043 Load-use hazard with flush=1 in the same cycle -> stall=0, ex_bubble=1, stall_cnt unchanged.
REQ-044 arst_n low mid-stall -> all outputs 0 next cycle; stall_cnt preset to all-ones plus one stall -> holds all-ones.
